// File: rtl/dac_5g_tx_framer_if.sv
// User-side word handshake into the DAC transmit framer: four I and four Q
// samples per word (index 0 earliest), a frame-sync tag and valid/ready.
interface dac_5g_tx_framer_if;
    logic [7:0] user_datai0;
    logic [7:0] user_datai1;
    logic [7:0] user_datai2;
    logic [7:0] user_datai3;
    logic [7:0] user_dataq0;
    logic [7:0] user_dataq1;
    logic [7:0] user_dataq2;
    logic [7:0] user_dataq3;
    logic       user_sync;
    logic       user_data_valid;
    logic       user_ready;

    modport master (
        output user_datai0, user_datai1, user_datai2, user_datai3,
        output user_dataq0, user_dataq1, user_dataq2, user_dataq3,
        output user_sync, user_data_valid,
        input  user_ready
    );

    modport slave (
        input  user_datai0, user_datai1, user_datai2, user_datai3,
        input  user_dataq0, user_dataq1, user_dataq2, user_dataq3,
        input  user_sync, user_data_valid,
        output user_ready
    );
endinterface

// File: rtl/dac_5g_tx_framer.sv
// DAC transmit framer: word FIFO feeding a 4:2 gearbox that emits rise/fall
// sample pairs for ODDR, with sync tagging, midscale idle, underflow recovery and a ramp source.
module dac_5g_tx_framer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                          ctrl_clk_in,
    input  logic                          ctrl_reset,
    dac_5g_tx_framer_if.slave             user,
    input  logic                          tx_enable,
    input  logic                          test_ramp,
    input  logic                          underflow_clr,
    output logic [7:0]                    dac_di_rise,
    output logic [7:0]                    dac_di_fall,
    output logic [7:0]                    dac_dq_rise,
    output logic [7:0]                    dac_dq_fall,
    output logic                          dac_sync,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_RAMP} state_t;

    typedef struct packed {
        logic [7:0] di_rise;
        logic [7:0] di_fall;
        logic [7:0] dq_rise;
        logic [7:0] dq_fall;
    } pair_t;

    localparam pair_t PAIR_MID = '{8'h80, 8'h80, 8'h80, 8'h80};

    state_t          state, state_n;
    logic            phase, phase_n;
    logic [7:0]      ramp, ramp_n;
    pair_t           hold, hold_n, out_q, out_n;
    logic            sync_n, set_uf, pop, flush, push;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [64:0]     mem [FIFO_DEPTH];
    logic [64:0]     head;

    assign user.user_ready = tx_enable & ~test_ramp & (fifo_level < LW'(FIFO_DEPTH));
    assign push            = user.user_data_valid & user.user_ready;
    assign head            = mem[rd_ptr];

    assign dac_di_rise = out_q.di_rise;
    assign dac_di_fall = out_q.di_fall;
    assign dac_dq_rise = out_q.dq_rise;
    assign dac_dq_fall = out_q.dq_fall;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        phase_n = phase;
        ramp_n  = ramp;
        hold_n  = hold;
        out_n   = PAIR_MID;
        sync_n  = 1'b0;
        set_uf  = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (!tx_enable) begin
            state_n = ST_IDLE;
            phase_n = 1'b0;
            flush   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    flush   = 1'b1;
                    phase_n = 1'b0;
                    ramp_n  = 8'h00;
                    state_n = test_ramp ? ST_RAMP : ST_PRIME;
                end
                ST_PRIME: begin
                    if (test_ramp)                           state_n = ST_IDLE;
                    else if (fifo_level >= LW'(PRIME_LEVEL)) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (test_ramp) begin
                        // Leaving the mode discards any half-sent word.
                        state_n = ST_IDLE;
                        phase_n = 1'b0;
                    end else if (phase) begin
                        out_n   = hold;
                        phase_n = 1'b0;
                    end else if (fifo_level == '0) begin
                        set_uf  = 1'b1;
                        state_n = ST_PRIME;
                    end else begin
                        pop     = 1'b1;
                        out_n   = '{head[7:0], head[15:8], head[39:32], head[47:40]};
                        hold_n  = '{head[23:16], head[31:24], head[55:48], head[63:56]};
                        sync_n  = head[64];
                        phase_n = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (!test_ramp) begin
                        state_n = ST_IDLE;
                    end else begin
                        out_n  = '{ramp, ramp + 8'd1, ~ramp, ~(ramp + 8'd1)};
                        sync_n = (ramp == 8'h00);
                        ramp_n = ramp + 8'd2;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            ramp      <= 8'h00;
            hold      <= PAIR_MID;
            out_q     <= PAIR_MID;
            dac_sync  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            ramp     <= ramp_n;
            hold     <= hold_n;
            out_q    <= out_n;
            dac_sync <= sync_n;
            if (set_uf)             underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end

    // A flush cycle empties the FIFO, but a word accepted in that same cycle lands in slot 0.
    always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= push ? AW'(1) : '0;
            rd_ptr     <= '0;
            fifo_level <= push ? LW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge ctrl_clk_in) begin
        if (push) begin
            mem[flush ? '0 : wr_ptr] <= {user.user_sync,
                                         user.user_dataq3, user.user_dataq2,
                                         user.user_dataq1, user.user_dataq0,
                                         user.user_datai3, user.user_datai2,
                                         user.user_datai1, user.user_datai0};
        end
    end
endmodule

// File: tb/tb_dac_5g_tx_framer.sv
// Scoreboard bench for dac_5g_tx_framer: a queue-based reference model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_dac_5g_tx_framer;
    localparam int DEPTH = 4;
    localparam int PRIME = 2;

    typedef struct packed {
        logic            sync;
        logic [3:0][7:0] q;
        logic [3:0][7:0] i;
    } word_t;

    typedef struct packed {
        logic [7:0] dir;
        logic [7:0] dif;
        logic [7:0] dqr;
        logic [7:0] dqf;
        logic       sync;
    } pair_t;

    typedef struct packed {
        logic [7:0] dir;
        logic [7:0] dif;
        logic [7:0] dqr;
        logic [7:0] dqf;
        logic       sync;
        logic       uf;
        logic [2:0] level;
    } exp_t;

    typedef enum {M_IDLE, M_PRIME, M_RUN, M_RAMP} mode_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b0;
    logic       test_ramp = 1'b0;
    logic       underflow_clr = 1'b0;
    logic [7:0] dac_di_rise, dac_di_fall, dac_dq_rise, dac_dq_fall;
    logic       dac_sync, underflow;
    logic [2:0] fifo_level;

    dac_5g_tx_framer_if u_if ();

    dac_5g_tx_framer #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
        .ctrl_clk_in   (clk),
        .ctrl_reset    (rst),
        .user          (u_if),
        .tx_enable     (tx_enable),
        .test_ramp     (test_ramp),
        .underflow_clr (underflow_clr),
        .dac_di_rise   (dac_di_rise),
        .dac_di_fall   (dac_di_fall),
        .dac_dq_rise   (dac_dq_rise),
        .dac_dq_fall   (dac_dq_fall),
        .dac_sync      (dac_sync),
        .underflow     (underflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t  exp_out_q[$];
    bit    exp_ready_q[$];
    word_t fifo_q[$];
    pair_t pair_q[$];
    mode_t m_mode;
    bit    m_uf;
    int unsigned ramp_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int k = 0; k < 4; k++) begin
            w.i[k] = 8'($urandom_range(0, 255));
            w.q[k] = 8'($urandom_range(0, 255));
        end
        w.sync = ($urandom_range(0, 3) == 0);
        return w;
    endfunction

    function automatic exp_t midscale_rec(input bit uf, input int level);
        exp_t e;
        e.dir = 8'h80; e.dif = 8'h80; e.dqr = 8'h80; e.dqf = 8'h80;
        e.sync = 1'b0; e.uf = uf; e.level = 3'(level);
        return e;
    endfunction

    // Predict this cycle's ready and the outputs that appear after the next edge.
    task automatic model_step(input bit en, input bit tr, input bit clr, input bit vld, input word_t w);
        exp_t  e;
        pair_t p;
        word_t h;
        bit    ready, push, set_uf;
        int    v;
        ready = en && !tr && (fifo_q.size() < DEPTH);
        exp_ready_q.push_back(ready);
        push   = vld && ready;
        set_uf = 1'b0;
        e = midscale_rec(1'b0, 0);
        if (!en) begin
            m_mode = M_IDLE;
            fifo_q.delete();
            pair_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    fifo_q.delete();
                    pair_q.delete();
                    ramp_n = 0;
                    m_mode = tr ? M_RAMP : M_PRIME;
                end
                M_PRIME: begin
                    if (tr) m_mode = M_IDLE;
                    else if (fifo_q.size() >= PRIME) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (tr) begin
                        m_mode = M_IDLE;
                        pair_q.delete();
                    end else begin
                        if (pair_q.size() == 0) begin
                            if (fifo_q.size() == 0) begin
                                set_uf = 1'b1;
                                m_mode = M_PRIME;
                            end else begin
                                h = fifo_q.pop_front();
                                p.dir = h.i[0]; p.dif = h.i[1]; p.dqr = h.q[0]; p.dqf = h.q[1]; p.sync = h.sync;
                                pair_q.push_back(p);
                                p.dir = h.i[2]; p.dif = h.i[3]; p.dqr = h.q[2]; p.dqf = h.q[3]; p.sync = 1'b0;
                                pair_q.push_back(p);
                            end
                        end
                        if (pair_q.size() != 0) begin
                            p = pair_q.pop_front();
                            e.dir = p.dir; e.dif = p.dif; e.dqr = p.dqr; e.dqf = p.dqf; e.sync = p.sync;
                        end
                    end
                end
                M_RAMP: begin
                    if (!tr) begin
                        m_mode = M_IDLE;
                    end else begin
                        v = int'((2 * ramp_n) % 256);
                        e.dir  = 8'(v);
                        e.dif  = 8'((v + 1) % 256);
                        e.dqr  = 8'(255 - v);
                        e.dqf  = 8'(255 - ((v + 1) % 256));
                        e.sync = (v == 0);
                        ramp_n++;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        if (push) fifo_q.push_back(w);
        if (set_uf)   m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
        e.uf    = m_uf;
        e.level = 3'(fifo_q.size());
        exp_out_q.push_back(e);
    endtask

    task automatic drive(input bit en, input bit tr, input bit clr, input bit vld, input word_t w);
        tx_enable             = en;
        test_ramp             = tr;
        underflow_clr         = clr;
        u_if.user_data_valid  = vld;
        u_if.user_sync        = w.sync;
        u_if.user_datai0 = w.i[0]; u_if.user_datai1 = w.i[1];
        u_if.user_datai2 = w.i[2]; u_if.user_datai3 = w.i[3];
        u_if.user_dataq0 = w.q[0]; u_if.user_dataq1 = w.q[1];
        u_if.user_dataq2 = w.q[2]; u_if.user_dataq3 = w.q[3];
    endtask

    task automatic cycle(input bit en, input bit tr, input bit clr, input bit vld, input word_t w);
        drive(en, tr, clr, vld, w);
        model_step(en, tr, clr, vld, w);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check("rst_di_rise", 32'(dac_di_rise), 32'h80);
        check("rst_di_fall", 32'(dac_di_fall), 32'h80);
        check("rst_dq_rise", 32'(dac_dq_rise), 32'h80);
        check("rst_dq_fall", 32'(dac_dq_fall), 32'h80);
        check("rst_sync", 32'(dac_sync), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ready", 32'(u_if.user_ready), 32'h0);
        exp_out_q.delete();
        exp_ready_q.delete();
        fifo_q.delete();
        pair_q.delete();
        m_mode = M_IDLE;
        m_uf   = 1'b0;
        ramp_n = 0;
        exp_out_q.push_back(midscale_rec(1'b0, 0));
        for (int k = 0; k < n; k++) begin
            exp_ready_q.push_back(1'b0);
            exp_out_q.push_back(midscale_rec(1'b0, 0));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   r;
        if (exp_out_q.size() != 0) begin
            e = exp_out_q.pop_front();
            check("di_rise", 32'(dac_di_rise), 32'(e.dir));
            check("di_fall", 32'(dac_di_fall), 32'(e.dif));
            check("dq_rise", 32'(dac_dq_rise), 32'(e.dqr));
            check("dq_fall", 32'(dac_dq_fall), 32'(e.dqf));
            check("dac_sync", 32'(dac_sync), 32'(e.sync));
            check("underflow", 32'(underflow), 32'(e.uf));
            check("fifo_level", 32'(fifo_level), 32'(e.level));
        end
        if (exp_ready_q.size() != 0) begin
            r = exp_ready_q.pop_front();
            check("user_ready", 32'(u_if.user_ready), 32'(r));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t wa, wb;
        bit    tr_r, en_r;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        do_reset(2);

        // Directed first frame with known samples and sync.
        for (int k = 0; k < 4; k++) begin
            wa.i[k] = 8'(8'h10 + k);
            wa.q[k] = 8'(8'h20 + k);
            wb.i[k] = 8'(8'h30 + k);
            wb.q[k] = 8'(8'h40 + k);
        end
        wa.sync = 1'b1;
        wb.sync = 1'b0;
        cycle(1, 0, 0, 1, wa);
        cycle(1, 0, 0, 1, wb);
        repeat (6) cycle(1, 0, 0, 0, rand_word());
        cycle(1, 0, 1, 0, rand_word());

        // Fill faster than the gearbox drains: ready drops at full.
        cycle(0, 0, 0, 0, rand_word());
        repeat (12) cycle(1, 0, 0, 1, rand_word());

        // Starve after three words, clear, then set and clear together.
        cycle(0, 0, 0, 0, rand_word());
        repeat (3) cycle(1, 0, 0, 1, rand_word());
        repeat (10) cycle(1, 0, 0, 0, rand_word());
        cycle(1, 0, 1, 0, rand_word());
        repeat (2) cycle(1, 0, 1, 1, rand_word());
        repeat (8) cycle(1, 0, 1, 0, rand_word());
        cycle(1, 0, 0, 0, rand_word());

        // Ramp source across more than two sync periods.
        repeat (300) cycle(1, 1, 0, 1'($urandom_range(0, 1)), rand_word());

        // Disable mid-run with words queued, then reset mid-run.
        repeat (6) cycle(1, 0, 0, 1, rand_word());
        cycle(0, 0, 0, 0, rand_word());
        repeat (5) cycle(1, 0, 0, 1, rand_word());
        do_reset(2);

        // Sustained one-word-per-two-cycles stream after priming.
        cycle(0, 0, 1, 0, rand_word());
        cycle(1, 0, 0, 1, rand_word());
        cycle(1, 0, 0, 1, rand_word());
        for (int k = 0; k < 40; k++) cycle(1, 0, 0, (k % 2 == 0), rand_word());

        // Randomized mode, handshake and clear traffic.
        tr_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            en_r = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 63) == 0) tr_r = !tr_r;
            cycle(en_r, tr_r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), rand_word());
        end
        cycle(0, 0, 0, 0, rand_word());

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
